// File: rtl/alarm_pkg.sv
// Alarm controller shared types: view/status encodings, BCD limits, reset alarm time.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Optional feature macro: ALARM_SNOOZE_EN adds the SNOOZE status encoding.
package alarm_pkg;

    // Which digits the operator is looking at / editing.
    typedef enum logic [1:0] {
        V_VIEW  = 2'd0,
        V_SET_H = 2'd1,
        V_SET_M = 2'd2
    } view_e;

    // Alarm sequencing state.
`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_ARM    = 2'd1,
        S_RING   = 2'd2,
        S_SNOOZE = 2'd3
    } status_e;
`else
    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ARM  = 2'd1,
        S_RING = 2'd2
    } status_e;
`endif

    // Alarm time as BCD HH:MM.
    typedef struct packed {
        logic [1:0] hh;
        logic [3:0] hl;
        logic [2:0] mh;
        logic [3:0] ml;
    } alm_t;

    // Last legal value of each BCD field (23 and 59).
    localparam logic [1:0] HOUR_MAX_H = 2'd2;
    localparam logic [3:0] HOUR_MAX_L = 4'd3;
    localparam logic [2:0] MIN_MAX_H  = 3'd5;
    localparam logic [3:0] MIN_MAX_L  = 4'd9;

    // Alarm value after reset: 07:00.
    localparam alm_t ALM_RST = {2'd0, 4'd7, 3'd0, 4'd0};

    // Second-timer width; covers the largest ring/snooze duration (1023 s).
    localparam int unsigned TMR_W = 10;

    // Hour +1 in BCD, 23 wraps to 00. Minute fields pass through untouched.
    function automatic alm_t hour_inc(input alm_t a);
        alm_t r;
        r = a;
        if (a.hh == HOUR_MAX_H && a.hl == HOUR_MAX_L) begin
            r.hh = 2'd0;
            r.hl = 4'd0;
        end else if (a.hl == 4'd9) begin
            r.hh = a.hh + 2'd1;
            r.hl = 4'd0;
        end else begin
            r.hl = a.hl + 4'd1;
        end
        return r;
    endfunction

    // Minute +1 in BCD, 59 wraps to 00 without carrying into the hour.
    function automatic alm_t min_inc(input alm_t a);
        alm_t r;
        r = a;
        if (a.mh == MIN_MAX_H && a.ml == MIN_MAX_L) begin
            r.mh = 3'd0;
            r.ml = 4'd0;
        end else if (a.ml == 4'd9) begin
            r.mh = a.mh + 3'd1;
            r.ml = 4'd0;
        end else begin
            r.ml = a.ml + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Seconds up-counter shared by RING and SNOOZE; pulses tc on the tick that reaches limit.
// Latency: tc is combinational on the terminal tick; count updates at the next core_clk edge.
// Backpressure: none; every tick is counted unless clr is asserted in the same cycle.
//
// Ports: core_clk, rst_n (sync, active-low), clr (sync clear, wins over tick),
//        tick (1 s enable), limit (duration in ticks, >= 1), tc (terminal-count pulse).
module alarm_sec_timer #(
    parameter int unsigned W = 10
) (
    input  logic         core_clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // tc fires on the limit-th tick since the last clear.
    assign tc = tick && (cnt_q == (limit - W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tc) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// DE0 clock alarm: BCD HH:MM alarm edit, time match, ring / snooze / timeout sequencing.
// Latency: every output is registered, 1 CLK after the causing pulse or time step.
// Backpressure: none; button pulses are acted on in the cycle they arrive or dropped.
//
// Optional feature macro: ALARM_SNOOZE_EN (SELECT while ringing snoozes for SNOOZE_SEC
// instead of stopping the ring).
// Ports: CLK, RST (sync, active-low), EN1HZ (1 s pulse), SIG2HZ (blink/tone),
//        MODE/SELECT/ADJUST (1-cycle button pulses), HOURH/HOURL/MINH/MINL/SECH/SECL (live time),
//        ALMHH/ALMHL/ALMMH/ALMML (alarm digits), ALMDISP, HOURON, MINON, ARMED, BUZZ.
module alarm_ctrl #(
    parameter int unsigned RING_SEC = 60
`ifdef ALARM_SNOOZE_EN
    , parameter int unsigned SNOOZE_SEC = 300
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic       SIG2HZ,
    input  logic       MODE,
    input  logic       SELECT,
    input  logic       ADJUST,
    input  logic [1:0] HOURH,
    input  logic [3:0] HOURL,
    input  logic [2:0] MINH,
    input  logic [3:0] MINL,
    input  logic [2:0] SECH,
    input  logic [3:0] SECL,
    output logic [1:0] ALMHH,
    output logic [3:0] ALMHL,
    output logic [2:0] ALMMH,
    output logic [3:0] ALMML,
    output logic       ALMDISP,
    output logic       HOURON,
    output logic       MINON,
    output logic       ARMED,
    output logic       BUZZ
);
    import alarm_pkg::*;

    localparam logic [TMR_W-1:0] RING_LIM   = TMR_W'(RING_SEC);
`ifdef ALARM_SNOOZE_EN
    localparam logic [TMR_W-1:0] SNOOZE_LIM = TMR_W'(SNOOZE_SEC);
`endif

    view_e   view_q,   view_d;
    status_e status_q, status_d;
    alm_t    alm_q,    alm_d;
    logic    match_q,  match_d;
    logic    almdisp_q, almdisp_d;
    logic    houron_q,  houron_d;
    logic    minon_q,   minon_d;
    logic    armed_q,   armed_d;
    logic    buzz_q,    buzz_d;

    logic              trigger;
    logic              tmr_tick;
    logic              tmr_clr;
    logic              tmr_tc;
    logic [TMR_W-1:0]  tmr_limit;

    // The timer only runs while ringing or snoozing and always starts from zero
    // on entry to either, so any status change clears it.
`ifdef ALARM_SNOOZE_EN
    assign tmr_tick  = EN1HZ && ((status_q == S_RING) || (status_q == S_SNOOZE));
    assign tmr_limit = (status_q == S_SNOOZE) ? SNOOZE_LIM : RING_LIM;
`else
    assign tmr_tick  = EN1HZ && (status_q == S_RING);
    assign tmr_limit = RING_LIM;
`endif
    assign tmr_clr   = (status_d != status_q);

    alarm_sec_timer #(
        .W (TMR_W)
    ) u_tmr (
        .core_clk (CLK),
        .rst_n    (RST),
        .clr      (tmr_clr),
        .tick     (tmr_tick),
        .limit    (tmr_limit),
        .tc       (tmr_tc)
    );

    always_comb begin
        // Level match for the whole of second :00; only its rising edge triggers,
        // so a ring that ends (or is stopped) inside that second cannot restart.
        match_d = (HOURH == alm_q.hh) && (HOURL == alm_q.hl) &&
                  (MINH  == alm_q.mh) && (MINL  == alm_q.ml) &&
                  (SECH == 3'd0) && (SECL == 4'd0);
        trigger = match_d && !match_q;

        view_d   = view_q;
        status_d = status_q;
        alm_d    = alm_q;

        if (trigger && (status_q == S_ARM)) begin
            // Trigger beats any same-cycle button and abandons editing.
            status_d = S_RING;
            view_d   = V_VIEW;
        end else begin
            case (status_q)
                S_RING: begin
                    // Buttons here only silence the alarm; they never edit or change view.
                    if (MODE) begin
                        status_d = S_ARM;
                    end else if (SELECT) begin
`ifdef ALARM_SNOOZE_EN
                        status_d = S_SNOOZE;
`else
                        status_d = S_ARM;
`endif
                    end else if (tmr_tc) begin
                        status_d = S_ARM;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (MODE) begin
                        status_d = S_ARM;
                    end else if (tmr_tc) begin
                        status_d = S_RING;
                    end
                end
`endif
                default: begin
                    // OFF / ARM: normal editing, MODE > SELECT > ADJUST.
                    if (MODE) begin
                        case (view_q)
                            V_VIEW:  view_d = V_SET_H;
                            V_SET_H: view_d = V_SET_M;
                            default: view_d = V_VIEW;
                        endcase
                    end else if (SELECT) begin
                        if (view_q == V_VIEW) begin
                            status_d = (status_q == S_OFF) ? S_ARM : S_OFF;
                        end
                    end else if (ADJUST) begin
                        if (view_q == V_SET_H) begin
                            alm_d = hour_inc(alm_q);
                        end else if (view_q == V_SET_M) begin
                            alm_d = min_inc(alm_q);
                        end
                    end
                end
            endcase
        end

        // Outputs are registered from next-state so they land 1 cycle after the cause.
        almdisp_d = (view_d != V_VIEW);
        houron_d  = (view_d == V_SET_H) ? SIG2HZ : 1'b1;
        minon_d   = (view_d == V_SET_M) ? SIG2HZ : 1'b1;
        armed_d   = (status_d != S_OFF);
        buzz_d    = (status_d == S_RING) ? SIG2HZ : 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            view_q    <= V_VIEW;
            status_q  <= S_OFF;
            alm_q     <= ALM_RST;
            match_q   <= 1'b0;
            almdisp_q <= 1'b0;
            houron_q  <= 1'b1;
            minon_q   <= 1'b1;
            armed_q   <= 1'b0;
            buzz_q    <= 1'b0;
        end else begin
            view_q    <= view_d;
            status_q  <= status_d;
            alm_q     <= alm_d;
            match_q   <= match_d;
            almdisp_q <= almdisp_d;
            houron_q  <= houron_d;
            minon_q   <= minon_d;
            armed_q   <= armed_d;
            buzz_q    <= buzz_d;
        end
    end

    assign ALMHH   = alm_q.hh;
    assign ALMHL   = alm_q.hl;
    assign ALMMH   = alm_q.mh;
    assign ALMML   = alm_q.ml;
    assign ALMDISP = almdisp_q;
    assign HOURON  = houron_q;
    assign MINON   = minon_q;
    assign ARMED   = armed_q;
    assign BUZZ    = buzz_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: button/edit vector table plus ring/snooze/reset sequences.
// Latency: outputs are compared #1 after the edge that follows each stimulus.
// Backpressure: n/a.
module tb_alarm_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN1HZ = 1'b0;
    logic       SIG2HZ = 1'b0;
    logic       MODE = 1'b0;
    logic       SELECT = 1'b0;
    logic       ADJUST = 1'b0;
    logic [1:0] HOURH = 2'd1;
    logic [3:0] HOURL = 4'd2;
    logic [2:0] MINH = 3'd3;
    logic [3:0] MINL = 4'd4;
    logic [2:0] SECH = 3'd5;
    logic [3:0] SECL = 4'd6;
    logic [1:0] ALMHH;
    logic [3:0] ALMHL;
    logic [2:0] ALMMH;
    logic [3:0] ALMML;
    logic       ALMDISP, HOURON, MINON, ARMED, BUZZ;

    int total = 0;
    int bad   = 0;

    alarm_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN1HZ   (EN1HZ),
        .SIG2HZ  (SIG2HZ),
        .MODE    (MODE),
        .SELECT  (SELECT),
        .ADJUST  (ADJUST),
        .HOURH   (HOURH),
        .HOURL   (HOURL),
        .MINH    (MINH),
        .MINL    (MINL),
        .SECH    (SECH),
        .SECL    (SECL),
        .ALMHH   (ALMHH),
        .ALMHL   (ALMHL),
        .ALMMH   (ALMMH),
        .ALMML   (ALMML),
        .ALMDISP (ALMDISP),
        .HOURON  (HOURON),
        .MINON   (MINON),
        .ARMED   (ARMED),
        .BUZZ    (BUZZ)
    );

    always #5 CLK = ~CLK;

    // {ALMDISP, HOURON, MINON, ARMED, BUZZ}
    function automatic logic [4:0] flags();
        return {ALMDISP, HOURON, MINON, ARMED, BUZZ};
    endfunction
    function automatic logic [7:0] hr();
        return {2'b00, ALMHH, ALMHL};
    endfunction
    function automatic logic [7:0] mn();
        return {1'b0, ALMMH, ALMML};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic m, input logic s, input logic a);
        MODE = m; SELECT = s; ADJUST = a;
        tick(1);
        MODE = 1'b0; SELECT = 1'b0; ADJUST = 1'b0;
    endtask

    // Live time as BCD bytes, e.g. set_live(8'h07, 8'h00, 8'h00).
    task automatic set_live(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        HOURH = h[5:4]; HOURL = h[3:0];
        MINH  = m[6:4]; MINL  = m[3:0];
        SECH  = s[6:4]; SECL  = s[3:0];
    endtask

    task automatic en_pulses(input int n);
        repeat (n) begin
            EN1HZ = 1'b1; tick(1);
            EN1HZ = 1'b0; tick(1);
        end
    endtask

    task automatic do_reset();
        MODE = 1'b0; SELECT = 1'b0; ADJUST = 1'b0; EN1HZ = 1'b0;
        set_live(8'h12, 8'h34, 8'h56);
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
    endtask

    // Armed with alarm 07:00, ring started on the 06:59:59 -> 07:00:00 step.
    task automatic start_ring();
        do_reset();
        SIG2HZ = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        set_live(8'h06, 8'h59, 8'h59);
        tick(2);
        set_live(8'h07, 8'h00, 8'h00);
        tick(1);
    endtask

    typedef struct {
        logic       mode, sel, adj, sig;
        logic [4:0] exp_flags;
        logic [7:0] exp_hr, exp_mn;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Edit/status vectors from reset, live time 12:34:56 (never matches).
        //            mode  sel   adj   sig   disp/hon/mon/arm/buzz  hr     mn
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b01110, 8'h07, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b10110, 8'h07, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b11110, 8'h07, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10110, 8'h07, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b11110, 8'h08, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10110, 8'h08, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b11110, 8'h08, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b11010, 8'h08, 8'h01};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01110, 8'h08, 8'h01};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b01100, 8'h08, 8'h01};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b11100, 8'h08, 8'h01};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b10100, 8'h08, 8'h01};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b10100, 8'h09, 8'h01};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b11100, 8'h10, 8'h01};

        // Reset state.
        SIG2HZ = 1'b1;
        do_reset();
        check("reset_flags", 32'(flags()), 32'(5'b01100));
        check("reset_hr", 32'(hr()), 32'h07);
        check("reset_mn", 32'(mn()), 32'h00);

        for (int i = 0; i < 14; i++) begin
            SIG2HZ = vecs[i].sig;
            pulse(vecs[i].mode, vecs[i].sel, vecs[i].adj);
            check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
            check($sformatf("vec%0d_hr", i), 32'(hr()), 32'(vecs[i].exp_hr));
            check($sformatf("vec%0d_mn", i), 32'(mn()), 32'(vecs[i].exp_mn));
        end

        // BCD wrap: hour 07 + 17 -> 00, minute 00 + 60 -> 00.
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            pulse(1'b0, 1'b0, 1'b1);
            if (i == 3)  check("hour_09_to_10", 32'(hr()), 32'h10);
            if (i == 16) check("hour_23", 32'(hr()), 32'h23);
            if (i == 17) check("hour_wrap", 32'(hr()), 32'h00);
        end
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 60; i++) begin
            pulse(1'b0, 1'b0, 1'b1);
            if (i == 10) check("min_09_to_10", 32'(mn()), 32'h10);
            if (i == 59) check("min_59", 32'(mn()), 32'h59);
            if (i == 60) check("min_wrap", 32'(mn()), 32'h00);
        end
        check("min_no_hour_carry", 32'(hr()), 32'h00);

        // Ring, tone follow, 60 s timeout, no retrigger while 07:00:00 persists.
        start_ring();
        check("ring_buzz_on", 32'(BUZZ), 32'd1);
        SIG2HZ = 1'b0; tick(1);
        check("ring_buzz_tone_lo", 32'(BUZZ), 32'd0);
        SIG2HZ = 1'b1; tick(1);
        check("ring_buzz_tone_hi", 32'(BUZZ), 32'd1);
        en_pulses(59);
        check("ring_59s_still_on", 32'(BUZZ), 32'd1);
        en_pulses(1);
        check("ring_timeout_flags", 32'(flags()), 32'(5'b01110));
        tick(5);
        check("no_retrigger", 32'(BUZZ), 32'd0);

        // SELECT while ringing.
        start_ring();
        pulse(1'b0, 1'b1, 1'b0);
        check("ring_select_flags", 32'(flags()), 32'(5'b01110));
`ifdef ALARM_SNOOZE_EN
        en_pulses(299);
        check("snooze_299s_quiet", 32'(BUZZ), 32'd0);
        en_pulses(1);
        check("snooze_rering", 32'(BUZZ), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        check("rering_mode_stop", 32'(flags()), 32'(5'b01110));
`else
        en_pulses(3);
        check("select_stays_arm", 32'(flags()), 32'(5'b01110));
`endif

        // MODE while ringing stops it and does not advance the view.
        start_ring();
        pulse(1'b1, 1'b0, 1'b0);
        check("ring_mode_flags", 32'(flags()), 32'(5'b01110));
        pulse(1'b1, 1'b0, 1'b0);
        check("mode_after_ring_set_h", 32'(ALMDISP), 32'd1);

        // Button in the trigger cycle is dropped.
        do_reset();
        SIG2HZ = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        set_live(8'h06, 8'h59, 8'h59);
        tick(2);
        set_live(8'h07, 8'h00, 8'h00);
        pulse(1'b1, 1'b0, 1'b0);
        check("trigger_beats_mode", 32'(flags()), 32'(5'b01111));

        // Trigger while OFF is ignored.
        do_reset();
        set_live(8'h06, 8'h59, 8'h59);
        tick(2);
        set_live(8'h07, 8'h00, 8'h00);
        tick(2);
        check("off_no_ring", 32'(flags()), 32'(5'b01100));

        // Trigger while editing minutes (alarm moved to 07:01), then reset mid-ring.
        do_reset();
        SIG2HZ = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check("set_m_alarm", 32'(mn()), 32'h01);
        set_live(8'h07, 8'h00, 8'h59);
        tick(2);
        check("set_m_before_trigger", 32'(flags()), 32'(5'b11110));
        set_live(8'h07, 8'h01, 8'h00);
        tick(1);
        check("set_m_trigger_flags", 32'(flags()), 32'(5'b01111));
        RST = 1'b0;
        tick(1);
        check("midring_reset_flags", 32'(flags()), 32'(5'b01100));
        check("midring_reset_hr", 32'(hr()), 32'h07);
        check("midring_reset_mn", 32'(mn()), 32'h00);
        RST = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
